// File: rtl/mips_pkg.sv
// Shared definitions for the front end of the pipeline.
// Holds default widths for the fetch path and the {pc, instr} record.
// Fetch and decode both use that record.
package mips_pkg;

  localparam int unsigned MIPS_ADDR_W   = 8;
  localparam int unsigned MIPS_DATA_W   = 16;
  localparam int unsigned MIPS_RESET_PC = 0;

  typedef struct packed {
    logic [MIPS_ADDR_W-1:0] pc;
    logic [MIPS_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of fetched {pc, instr} records.
//   clk, rst_n   : clock, async active-low reset (clears storage too)
//   push_i       : write wdata_i at tail
//   pop_i        : advance head
//   flush_i      : drop all entries; wins over push/pop
//   wdata_i      : entry to write
//   head_o       : entry at head (meaningful when count_o != 0)
//   count_o      : occupancy 0..2
module fetch_fifo
  import mips_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     wdata_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       wptr_q, rptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // The upstream credit rule must keep these from ever happening.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && count_q == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !flush_i && count_q == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 1-cycle-latency ROM.
//   clk, rst           : clock, async active-low reset
//   i_en               : fetch enable (gates new requests only)
//   i_redirect/_pc     : load new PC, flush in-flight and buffered words
//   o_rom_rd/_raddr    : ROM read strobe / word address
//   i_rom_rdata        : ROM data, valid the cycle after o_rom_rd
//   o_valid/o_instr/o_pc, i_ready : valid/ready handshake to decode
// One request may be in flight. A request issues only if the buffered
// word, the in-flight word and the new word all fit in the 2-entry buffer.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W   = MIPS_ADDR_W,
  parameter int unsigned DATA_W   = MIPS_DATA_W,
  parameter int unsigned RESET_PC = MIPS_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_rom_rd,
  output logic [ADDR_W-1:0] o_rom_raddr,
  input  logic [DATA_W-1:0] i_rom_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_ready
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pend_pc_q;
  logic              pend_q;
  logic [1:0]        count;
  entry_t            head, wdata;
  logic [2:0]        occ;
  logic              pop, push, issue;

  assign o_valid = (count != 2'd0);
  assign pop     = o_valid & i_ready;
  // pop implies count >= 1, so this never underflows.
  assign occ     = {1'b0, count} + {2'b00, pend_q} - {2'b00, pop};
  // Gated by rst so the strobe reads 0 while reset is held.
  assign issue   = rst & i_en & ~i_redirect & (occ < 3'd2);
  // Data returning in a redirect cycle belongs to the old stream.
  assign push    = pend_q & ~i_redirect;

  assign o_rom_rd    = issue;
  assign o_rom_raddr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= PC_RST;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (i_redirect) begin
      pc_q   <= i_redirect_pc;
      pend_q <= 1'b0;
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_pc_q <= pc_q;
        pc_q      <= pc_q + 1'b1;
      end
    end
  end

  assign wdata = '{pc: pend_pc_q, instr: i_rom_rdata};

  fetch_fifo #(.entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_redirect),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  assign o_instr = head.instr;
  assign o_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_redirect, i_ready;
  logic [7:0]  i_redirect_pc;
  logic        o_rom_rd, o_valid;
  logic [7:0]  o_rom_raddr, o_pc;
  logic [15:0] i_rom_rdata, o_instr;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM model: word[a] = {8'hA5, a}, one-cycle read latency, holds when idle.
  initial i_rom_rdata = 16'h0;
  always @(posedge clk) if (o_rom_rd) i_rom_rdata <= {8'hA5, o_rom_raddr};

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_rom_rd      (o_rom_rd),
    .o_rom_raddr   (o_rom_raddr),
    .i_rom_rdata   (i_rom_rdata),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready)
  );

  typedef struct {
    logic       en, rdy, redir;
    logic [7:0] rpc;
    logic       rd;
    logic [7:0] raddr;
    logic       vld;
    logic [7:0] pc;   // head pc; expected instr is {8'hA5, pc}
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic en, logic rdy, logic redir, logic [7:0] rpc,
                             logic rd, logic [7:0] raddr, logic vld, logic [7:0] pc);
    vec_t r;
    r.en = en; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.rd = rd; r.raddr = raddr; r.vld = vld; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic [7:0] raddr,
                         input logic vld, input logic [7:0] pc);
    chk({tag, " rom_rd"},    32'(o_rom_rd),    32'(rd));
    chk({tag, " rom_raddr"}, 32'(o_rom_raddr), 32'(raddr));
    chk({tag, " valid"},     32'(o_valid),     32'(vld));
    if (vld) begin
      chk({tag, " pc"},    32'(o_pc),    32'(pc));
      chk({tag, " instr"}, 32'(o_instr), 32'({8'hA5, pc}));
    end
  endtask

  initial begin
    // stream from reset
    tv.push_back(v(1,1,0,8'h00, 1,8'h00, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h01, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h02, 1,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h03, 1,8'h01));
    tv.push_back(v(1,1,0,8'h00, 1,8'h04, 1,8'h02));
    // back-pressure for 5 cycles: head held, requests stop
    for (int i = 0; i < 5; i++) tv.push_back(v(1,0,0,8'h00, 0,8'h05, 1,8'h03));
    tv.push_back(v(1,1,0,8'h00, 1,8'h05, 1,8'h03));
    tv.push_back(v(1,1,0,8'h00, 1,8'h06, 1,8'h04));
    tv.push_back(v(1,1,0,8'h00, 1,8'h07, 1,8'h05));
    // redirect with one buffered word and one in flight
    tv.push_back(v(1,0,1,8'h40, 0,8'h08, 1,8'h06));
    tv.push_back(v(1,1,0,8'h00, 1,8'h40, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h41, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h42, 1,8'h40));
    tv.push_back(v(1,1,0,8'h00, 1,8'h43, 1,8'h41));
    // redirect near the top of the address space, pop in the redirect cycle
    tv.push_back(v(1,1,1,8'hFE, 0,8'h44, 1,8'h42));
    tv.push_back(v(1,1,0,8'h00, 1,8'hFE, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'hFF, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h00, 1,8'hFE));
    tv.push_back(v(1,1,0,8'h00, 1,8'h01, 1,8'hFF));
    tv.push_back(v(1,1,0,8'h00, 1,8'h02, 1,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h03, 1,8'h01));
    // fetch disabled for 3 cycles: in-flight word lands, buffer drains
    tv.push_back(v(0,1,0,8'h00, 0,8'h04, 1,8'h02));
    tv.push_back(v(0,1,0,8'h00, 0,8'h04, 1,8'h03));
    tv.push_back(v(0,1,0,8'h00, 0,8'h04, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h04, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h05, 0,8'h00));
    tv.push_back(v(1,1,0,8'h00, 1,8'h06, 1,8'h04));

    // reset state, with enable already high
    rst = 1'b0; i_en = 1'b1; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = 8'h00;
    #2;
    n_vec++;
    chk("reset rom_rd",    32'(o_rom_rd),    32'd0);
    chk("reset rom_raddr", 32'(o_rom_raddr), 32'd0);
    chk("reset valid",     32'(o_valid),     32'd0);
    chk("reset instr",     32'(o_instr),     32'd0);
    chk("reset pc",        32'(o_pc),        32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tv[i]) begin
      i_en = tv[i].en; i_ready = tv[i].rdy;
      i_redirect = tv[i].redir; i_redirect_pc = tv[i].rpc;
      #3;
      n_vec++;
      chk_out($sformatf("vec%0d", i), tv[i].rd, tv[i].raddr, tv[i].vld, tv[i].pc);
      @(posedge clk); #1;
    end

    // async reset mid-stream with a request in flight (pc 06)
    i_en = 1'b1; i_ready = 1'b1; i_redirect = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    chk("midrst rom_rd",    32'(o_rom_rd),    32'd0);
    chk("midrst rom_raddr", 32'(o_rom_raddr), 32'd0);
    chk("midrst valid",     32'(o_valid),     32'd0);
    chk("midrst instr",     32'(o_instr),     32'd0);
    chk("midrst pc",        32'(o_pc),        32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    // stale ROM word from before reset must not be delivered
    #3; n_vec++; chk_out("rst r0", 1'b1, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #4; n_vec++; chk_out("rst r1", 1'b1, 8'h01, 1'b0, 8'h00);
    @(posedge clk); #4; n_vec++; chk_out("rst r2", 1'b1, 8'h02, 1'b1, 8'h00);
    @(posedge clk); #4; n_vec++; chk_out("rst r3", 1'b1, 8'h03, 1'b1, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
